// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
// merge() works at a fixed maximum width so any DATA_W up to MAX_DATA_W can reuse it.
package dpram_pkg;

    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    localparam int MAX_DATA_W = 256;

    function automatic int lanes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    // A lane takes new_word where its active-low mask bit is 0, else keeps old_word.
    function automatic logic [MAX_DATA_W-1:0] merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_DATA_W-1:0] bweb,
        input int                    byte_w
    );
        logic [MAX_DATA_W-1:0] result;
        result = old_word;
        for (int b = 0; b < MAX_DATA_W; b++) begin
            if (!bweb[8'(b / byte_w)]) begin
                result[8'(b)] = new_word[8'(b)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dpram_port_out.sv
// Per-port read data path: stage-1 data register, optional stage-2 register
// and combinational output-enable gating.
module dpram_port_out #(
    parameter int DATA_W  = 32,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              oeb,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] stage1;
    logic [DATA_W-1:0] data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= '0;
        end else if (load) begin
            stage1 <= din;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_stage2
            logic              valid1;
            logic [DATA_W-1:0] stage2;

            // Stage 2 only follows a fresh stage-1 load, so idle ports hold their word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid1 <= 1'b0;
                    stage2 <= '0;
                end else begin
                    valid1 <= load;
                    if (valid1) begin
                        stage2 <= stage1;
                    end
                end
            end

            assign data = stage2;
        end else begin : g_stage1
            assign data = stage1;
        end
    endgenerate

    assign dout = oeb ? '0 : data;

endmodule

// File: rtl/dpram_param.sv
// Parametrised true dual-port synchronous RAM with byte masks, selectable
// read-during-write, per-lane write/write resolution and collision/range flags.
module dpram_param
    import dpram_pkg::*;
#(
    parameter int        ADDR_W   = 5,
    parameter int        DATA_W   = 32,
    parameter int        DEPTH    = 32,
    parameter int        BYTE_W   = 8,
    parameter int        OUT_REG  = 0,
    parameter rdw_mode_e RDW_MODE = RDW_READ_FIRST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ceb1,
    input  logic                     ceb2,
    input  logic                     web1,
    input  logic                     web2,
    input  logic                     oeb1,
    input  logic                     oeb2,
    input  logic [DATA_W/BYTE_W-1:0] bweb1,
    input  logic [DATA_W/BYTE_W-1:0] bweb2,
    input  logic [ADDR_W-1:0]        a1,
    input  logic [ADDR_W-1:0]        a2,
    input  logic [DATA_W-1:0]        i1,
    input  logic [DATA_W-1:0]        i2,
    output logic [DATA_W-1:0]        o1,
    output logic [DATA_W-1:0]        o2,
    output logic                     collide,
    output logic                     oor
);

    localparam int              LANES   = lanes(DATA_W, BYTE_W);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              act1, act2, we1, we2, in1, in2;
    logic              same_addr, same_ww;
    logic [DATA_W-1:0] old1, old2, wdata1, wdata2, dout1, dout2;
    logic              collide_d, oor_d, collide_q, oor_q;

    function automatic logic [DATA_W-1:0] mrg(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [LANES-1:0]  mask
    );
        logic [MAX_DATA_W-1:0] p_old, p_new, p_mask, p_res;
        p_old                = '0;
        p_new                = '0;
        p_mask               = '1;
        p_old[DATA_W-1:0]    = old_word;
        p_new[DATA_W-1:0]    = new_word;
        p_mask[LANES-1:0]    = mask;
        p_res                = merge(p_old, p_new, p_mask, BYTE_W);
        return p_res[DATA_W-1:0];
    endfunction

    // Accesses are ignored while reset is held so no write lands on a reset edge.
    assign act1      = ~ceb1 & rst_n;
    assign act2      = ~ceb2 & rst_n;
    assign we1       = act1 & ~web1;
    assign we2       = act2 & ~web2;
    assign in1       = {1'b0, a1} < DEPTH_V;
    assign in2       = {1'b0, a2} < DEPTH_V;
    assign same_addr = (a1 == a2);
    assign same_ww   = we1 & we2 & same_addr & in1;

    assign old1 = in1 ? mem[a1] : '0;
    assign old2 = in2 ? mem[a2] : '0;

    // On a shared write address port 1 is merged on top of port 2, so it wins shared lanes.
    always_comb begin
        wdata2 = mrg(old2, i2, bweb2);
        wdata1 = mrg(same_ww ? wdata2 : old1, i1, bweb1);
    end

    always_ff @(posedge clk) begin
        if (we1 && in1) begin
            mem[a1] <= wdata1;
        end
        if (we2 && in2 && !same_ww) begin
            mem[a2] <= wdata2;
        end
    end

    always_comb begin
        dout1 = old1;
        dout2 = old2;
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            if (we1) begin
                dout1 = in1 ? wdata1 : '0;
            end
            if (we2) begin
                dout2 = in2 ? (same_ww ? wdata1 : wdata2) : '0;
            end
        end
    end

    assign collide_d = act1 & act2 & same_addr & (we1 | we2);
    assign oor_d     = (act1 & ~in1) | (act2 & ~in2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collide_q <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            collide_q <= collide_d;
            oor_q     <= oor_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_flag2
            logic collide_q2, oor_q2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    collide_q2 <= 1'b0;
                    oor_q2     <= 1'b0;
                end else begin
                    collide_q2 <= collide_q;
                    oor_q2     <= oor_q;
                end
            end

            assign collide = collide_q2;
            assign oor     = oor_q2;
        end else begin : g_flag1
            assign collide = collide_q;
            assign oor     = oor_q;
        end
    endgenerate

    dpram_port_out #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_out1 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (act1),
        .oeb   (oeb1),
        .din   (dout1),
        .dout  (o1)
    );

    dpram_port_out #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_out2 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (act2),
        .oeb   (oeb2),
        .din   (dout2),
        .dout  (o2)
    );

endmodule

// File: tb/tb_dpram_param.sv
// Directed bench for dpram_param: two instances share stimulus, one with
// DEPTH=20/OUT_REG=0/read-first and one with DEPTH=32/OUT_REG=1/write-first.
module tb_dpram_param;
    import dpram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ceb1, ceb2, web1, web2, oeb1, oeb2;
    logic [3:0]  bweb1, bweb2;
    logic [4:0]  a1, a2;
    logic [31:0] i1, i2;
    logic [31:0] oa1, oa2, ob1, ob2;
    logic        ca, ra, cb, rb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dpram_param #(
        .ADDR_W(5), .DATA_W(32), .DEPTH(20), .BYTE_W(8),
        .OUT_REG(0), .RDW_MODE(RDW_READ_FIRST)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .ceb1(ceb1), .ceb2(ceb2), .web1(web1), .web2(web2),
        .oeb1(oeb1), .oeb2(oeb2), .bweb1(bweb1), .bweb2(bweb2), .a1(a1), .a2(a2),
        .i1(i1), .i2(i2), .o1(oa1), .o2(oa2), .collide(ca), .oor(ra)
    );

    dpram_param #(
        .ADDR_W(5), .DATA_W(32), .DEPTH(32), .BYTE_W(8),
        .OUT_REG(1), .RDW_MODE(RDW_WRITE_FIRST)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ceb1(ceb1), .ceb2(ceb2), .web1(web1), .web2(web2),
        .oeb1(oeb1), .oeb2(oeb2), .bweb1(bweb1), .bweb2(bweb2), .a1(a1), .a2(a2),
        .i1(i1), .i2(i2), .o1(ob1), .o2(ob2), .collide(cb), .oor(rb)
    );

    task automatic idle();
        ceb1 = 1'b1; ceb2 = 1'b1; web1 = 1'b1; web2 = 1'b1;
        bweb1 = 4'b0000; bweb2 = 4'b0000;
        a1 = '0; a2 = '0; i1 = '0; i2 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (oa1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_oa1: got %h expected %h", oa1, 32'h0); end
        checks++; if (ob2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_ob2: got %h expected %h", ob2, 32'h0); end
        checks++; if ({ca, ra, cb, rb} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected %b", {ca, ra, cb, rb}, 4'b0); end
        step();
        step();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        idle(); ceb1 = 0; web1 = 0; a1 = 5'd3; i1 = 32'hDEADBEEF;
        step();
        a1 = 5'd4; i1 = 32'h0BADF00D;
        step();
        idle(); ceb1 = 0; a1 = 5'd3;
        step();
        checks++; if (oa1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_oa1: got %h expected %h", oa1, 32'hDEADBEEF); end
        checks++; if (ob1 !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL rd_ob1_latency: got %h expected %h", ob1, 32'h0BADF00D); end
        idle(); ceb2 = 0; a2 = 5'd3;
        step();
        checks++; if (oa2 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_oa2: got %h expected %h", oa2, 32'hDEADBEEF); end
        checks++; if (ob1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_ob1: got %h expected %h", ob1, 32'hDEADBEEF); end
        checks++; if (oa1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_oa1_hold: got %h expected %h", oa1, 32'hDEADBEEF); end
        idle();
        step();
        checks++; if (ob2 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_ob2: got %h expected %h", ob2, 32'hDEADBEEF); end
        checks++; if (ob1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_ob1_hold: got %h expected %h", ob1, 32'hDEADBEEF); end
    endtask

    task automatic test_byte_mask();
        idle(); ceb1 = 0; web1 = 0; a1 = 5'd7; i1 = 32'h11223344;
        step();
        i1 = 32'hAABBCCDD; bweb1 = 4'b1010;
        step();
        checks++; if (oa1 !== 32'h11223344) begin errors++; $display("[TB] FAIL mask_read_first: got %h expected %h", oa1, 32'h11223344); end
        idle(); ceb2 = 0; a2 = 5'd7;
        step();
        checks++; if (oa2 !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL mask_oa2: got %h expected %h", oa2, 32'h11BB33DD); end
        checks++; if (ob1 !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL mask_write_first: got %h expected %h", ob1, 32'h11BB33DD); end
        idle();
        step();
        checks++; if (ob2 !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL mask_ob2: got %h expected %h", ob2, 32'h11BB33DD); end
    endtask

    task automatic test_rdw();
        idle(); ceb1 = 0; web1 = 0; a1 = 5'd5; i1 = 32'h0;
        step();
        i1 = 32'h12345678; ceb2 = 0; a2 = 5'd5;
        step();
        checks++; if (oa1 !== 32'h0) begin errors++; $display("[TB] FAIL rdw_oa1: got %h expected %h", oa1, 32'h0); end
        checks++; if (oa2 !== 32'h0) begin errors++; $display("[TB] FAIL rdw_oa2: got %h expected %h", oa2, 32'h0); end
        checks++; if (ca !== 1'b1) begin errors++; $display("[TB] FAIL rdw_collide_a: got %b expected %b", ca, 1'b1); end
        idle();
        step();
        checks++; if (ob1 !== 32'h12345678) begin errors++; $display("[TB] FAIL rdw_ob1: got %h expected %h", ob1, 32'h12345678); end
        checks++; if (ob2 !== 32'h0) begin errors++; $display("[TB] FAIL rdw_ob2: got %h expected %h", ob2, 32'h0); end
        checks++; if ({ca, cb} !== 2'b01) begin errors++; $display("[TB] FAIL rdw_collide_pulse: got %b expected %b", {ca, cb}, 2'b01); end
    endtask

    task automatic test_collision();
        idle();
        ceb1 = 0; web1 = 0; a1 = 5'd9; i1 = 32'hFFFF0000; bweb1 = 4'b0011;
        ceb2 = 0; web2 = 0; a2 = 5'd9; i2 = 32'h0000AAAA; bweb2 = 4'b0000;
        step();
        checks++; if (ca !== 1'b1) begin errors++; $display("[TB] FAIL ww_collide_a: got %b expected %b", ca, 1'b1); end
        idle(); ceb1 = 0; a1 = 5'd9;
        step();
        checks++; if (oa1 !== 32'hFFFFAAAA) begin errors++; $display("[TB] FAIL ww_word: got %h expected %h", oa1, 32'hFFFFAAAA); end
        checks++; if ({ca, cb} !== 2'b01) begin errors++; $display("[TB] FAIL ww_collide_one: got %b expected %b", {ca, cb}, 2'b01); end
        checks++; if (ob2 !== 32'hFFFFAAAA) begin errors++; $display("[TB] FAIL ww_ob2_merged: got %h expected %h", ob2, 32'hFFFFAAAA); end
        idle();
        step();
        checks++; if (ob1 !== 32'hFFFFAAAA) begin errors++; $display("[TB] FAIL ww_ob1: got %h expected %h", ob1, 32'hFFFFAAAA); end
        checks++; if (cb !== 1'b0) begin errors++; $display("[TB] FAIL ww_collide_b_clear: got %b expected %b", cb, 1'b0); end
    endtask

    task automatic test_oor();
        idle(); ceb1 = 0; web1 = 0; a1 = 5'd25; i1 = 32'h55555555;
        step();
        checks++; if (ra !== 1'b1) begin errors++; $display("[TB] FAIL oor_write_flag: got %b expected %b", ra, 1'b1); end
        checks++; if (oa1 !== 32'h0) begin errors++; $display("[TB] FAIL oor_write_data: got %h expected %h", oa1, 32'h0); end
        idle(); ceb1 = 0; a1 = 5'd25;
        step();
        checks++; if (ra !== 1'b1) begin errors++; $display("[TB] FAIL oor_read_flag: got %b expected %b", ra, 1'b1); end
        checks++; if (oa1 !== 32'h0) begin errors++; $display("[TB] FAIL oor_read_data: got %h expected %h", oa1, 32'h0); end
        checks++; if (rb !== 1'b0) begin errors++; $display("[TB] FAIL oor_in_range_b: got %b expected %b", rb, 1'b0); end
        ceb2 = 0; a2 = 5'd30;
        step();
        checks++; if (ra !== 1'b1) begin errors++; $display("[TB] FAIL oor_both_flag: got %b expected %b", ra, 1'b1); end
        idle(); ceb1 = 0; a1 = 5'd3; ceb2 = 0; a2 = 5'd7;
        step();
        checks++; if (oa1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL oor_word3: got %h expected %h", oa1, 32'hDEADBEEF); end
        checks++; if (oa2 !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL oor_word7: got %h expected %h", oa2, 32'h11BB33DD); end
        checks++; if (ra !== 1'b0) begin errors++; $display("[TB] FAIL oor_clear: got %b expected %b", ra, 1'b0); end
    endtask

    task automatic test_reset_oeb();
        idle();
        step();
        checks++; if (ob1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL oeb_ob1_pre: got %h expected %h", ob1, 32'hDEADBEEF); end
        oeb1 = 1'b1;
        #1;
        checks++; if (oa1 !== 32'h0) begin errors++; $display("[TB] FAIL oeb_oa1_off: got %h expected %h", oa1, 32'h0); end
        checks++; if (ob1 !== 32'h0) begin errors++; $display("[TB] FAIL oeb_ob1_off: got %h expected %h", ob1, 32'h0); end
        oeb1 = 1'b0;
        #1;
        checks++; if (oa1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL oeb_oa1_on: got %h expected %h", oa1, 32'hDEADBEEF); end
        checks++; if (ob1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL oeb_ob1_on: got %h expected %h", ob1, 32'hDEADBEEF); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({oa1, oa2, ob1, ob2} !== 128'h0) begin errors++; $display("[TB] FAIL rst_mid_data: got %h expected %h", {oa1, oa2, ob1, ob2}, 128'h0); end
        checks++; if ({ca, ra, cb, rb} !== 4'b0) begin errors++; $display("[TB] FAIL rst_mid_flags: got %b expected %b", {ca, ra, cb, rb}, 4'b0); end
        ceb1 = 0; web1 = 0; a1 = 5'd3; i1 = 32'h0;
        step();
        idle();
        #2 rst_n = 1'b1;
        checks++; if (oa1 !== 32'h0) begin errors++; $display("[TB] FAIL rst_release_oa1: got %h expected %h", oa1, 32'h0); end
        ceb1 = 0; a1 = 5'd3;
        step();
        checks++; if (oa1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rst_retained_a: got %h expected %h", oa1, 32'hDEADBEEF); end
        idle();
        step();
        checks++; if (ob1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rst_retained_b: got %h expected %h", ob1, 32'hDEADBEEF); end
    endtask

    initial begin
        rst_n = 1'b0;
        oeb1  = 1'b0;
        oeb2  = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_byte_mask();
        test_rdw();
        test_collision();
        test_oor();
        test_reset_oeb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dpram_param.md
# dpram_param

Parametrised true dual-port synchronous RAM that succeeds the fixed 32x32 dual-port macro model used by the ML accelerator buffers. Both ports read and write independently on one clock. The block adds:
- configurable width and depth;
- active-low per-byte write masks;
- an optional output pipeline register;
- selectable same-port read-during-write behaviour;
- defined cross-port collision resolution with a collision flag.

## Interface
- ADDR_W, 5, address width
- DATA_W, 32, word width; must be a multiple of BYTE_W
- DEPTH, 32, number of words; must be at most 2**ADDR_W
- BYTE_W, 8, bits per byte-mask lane
- OUT_REG, 0, 1 adds one output pipeline stage
- RDW_MODE, RDW_READ_FIRST, same-port read-during-write: RDW_READ_FIRST (old data) or RDW_WRITE_FIRST (new merged data)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ceb1 / ceb2  in  1  active-low port enable
- web1 / web2  in  1  active-low write enable; 1 means read
- oeb1 / oeb2  in  1  active-low output enable
- bweb1 / bweb2  in  DATA_W/BYTE_W  active-low byte write mask; 0 means the lane is written
- a1 / a2  in  ADDR_W  word address
- i1 / i2  in  DATA_W  write data
- o1 / o2  out  DATA_W  read data
- collide  out  1  cross-port collision flag, aligned with read data
- oor  out  1  out-of-range access flag, aligned with read data

## Operation
- **Access:** a port is active when ceb=0 at a rising clk edge. A write is web=0; a read is web=1. Inactive ports hold their o value.
- **Write:** only lanes with bweb=0 are updated. A write with bweb all ones changes nothing.
- **Write data on o:** a write also produces data on o according to RDW_MODE:
  - RDW_READ_FIRST: o shows the pre-write word.
  - RDW_WRITE_FIRST: o shows the merged post-write word.
- **Cross-port write/read, same address:** the reading port always gets the old word.
- **Cross-port write/write, same address:** resolved per lane. Port 1 wins lanes that both ports write. Lanes written by only one port take that port's data.
- **collide:** asserted for one data slot when both ports are active on the same address and at least one is writing. Read/read on the same address does not set collide.
- **Out of range (a >= DEPTH):** the write is dropped, the read returns 0, and oor is asserted for that slot. If both ports are out of range in the same cycle, oor is still a single bit.
- **oeb:** oeb=1 forces o to 0 combinationally. The underlying data register keeps its value, so o reappears when oeb returns to 0.
- **Memory contents** are not reset; their power-up value is X.

## Timing
- **Read latency:** 1 + OUT_REG cycles from the enabling edge to valid o. collide and oor follow the same latency.
- **Throughput:** one access per port per cycle, no stalls.
- **Reset:** o1, o2, collide and oor go to 0 asynchronously and stay 0 while rst_n=0. Pipeline registers also clear. Memory is retained.
- **Reset edge:** a write sampled at an edge while rst_n=0 is not performed. The first access is accepted at the first rising edge after rst_n deasserts.
- **collide / oor without output data:** both flags are registered whether or not the ports are reading. Examples: a write/write collision, or an out-of-range write.
- **Pipeline hold:** with OUT_REG=1, the stage-2 register loads only when stage 1 held a new read in the previous cycle. It holds otherwise, as stage 1 does.

## Structure
- **Package dpram_pkg:**
  - enum rdw_mode_e with values RDW_READ_FIRST and RDW_WRITE_FIRST;
  - function lanes(DATA_W, BYTE_W);
  - function merge(old, new, bweb), which performs the byte-wise masked merge.
- **Sub-module dpram_port_out:** instantiated once per port. It contains the stage-1 data register, the optional stage-2 register and the oeb gating, and is parametrised by DATA_W and OUT_REG.
- **Top level:** holds the storage array, cross-port resolution, and the collide/oor flag pipeline.

## Test plan
- **Write then read, OUT_REG=0:**
  - Stimulus: write 0xDEADBEEF to a1=3; next cycle read a1=3, then read a2=3.
  - Required: o1=0xDEADBEEF one cycle after the read edge. Port 2 returns the same value.
  - Repeat with OUT_REG=1: data arrives two cycles after the read edge.
- **Byte mask:**
  - Stimulus: word 7 holds 0x11223344; write 0xAABBCCDD with bweb=4'b1010.
  - Required: readback 0x11BB33DD.
- **Read-during-write:**
  - Stimulus: word 5 holds 0x0; port 1 writes 0x12345678 to word 5.
  - Required: o1=0x0 under RDW_READ_FIRST and 0x12345678 under RDW_WRITE_FIRST.
  - Required: a port-2 read of word 5 in the same cycle returns 0x0 in both modes.
- **Write/write collision:**
  - Stimulus: both ports write word 9 in the same cycle. Port 1 writes 0xFFFF0000 with bweb=4'b0011; port 2 writes 0x0000AAAA with bweb=4'b0000.
  - Required: word 9 reads 0xFFFFAAAA, and collide=1 for exactly one cycle.
- **Out of range:**
  - Stimulus: DEPTH=20, write to address 25, then read address 25.
  - Required: oor=1 on both accesses, read returns 0, and no in-range word changes.
- **Reset and oeb:**
  - Stimulus: assert rst_n=0 mid-stream between clock edges.
  - Required: o1, o2, collide and oor read 0 immediately; earlier written data reads back correctly after release.
  - Required: oeb1=1 gives o1=0, and oeb1=0 restores the held word.
